packet_buffer_fifo: RTL and testbench
=====================================

# packet_buffer_fifo

Single-clock, parametrised packet FIFO that supersedes the fixed 1024×8 packet data RAM in the packet transmit path. Writers stream words of a packet, then commit or abort the packet. Only committed packets become visible to the reader, together with their length. Sits between the packet assembler and the UDP/Ethernet transmit framer.

## Interface

Parameters:
- DATA_W, default 8: word width.
- ADDR_W, default 10: depth is 2^ADDR_W words.
- MAX_PKTS, default 4: descriptor FIFO depth; must be a power of 2.
- LEN_W, default ADDR_W+1: width of packet lengths and free-word count.

Ports:
- Clock  in  1  single clock; all logic is on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- WrEn  in  1  write WrData into the current packet.
- WrData  in  DATA_W  write word.
- WrCommit  in  1  end of packet; a word written by WrEn in the same cycle is included.
- WrAbort  in  1  discard the current uncommitted packet.
- WrReady  out  1  one more word can be accepted.
- FreeWords  out  LEN_W  free words = DEPTH − (wr_ptr − rd_ptr).
- Overflow  out  1  one-cycle pulse when WrEn arrives while WrReady=0.
- Drop  out  1  one-cycle pulse when a commit is discarded because the packet overflowed.
- PktAvail  out  1  at least one committed packet is pending.
- PktLen  out  LEN_W  length of the head packet; 0 when PktAvail=0.
- RdEn  in  1  read the next word of the head packet.
- RdData  out  DATA_W  read word.
- RdValid  out  1  RdData is valid.
- RdLast  out  1  asserted with RdValid on the final word of a packet.

## Operation

- Storage is a 2^ADDR_W×DATA_W RAM with a synchronous read port. RAM contents are not reset.
- Pointers wr_ptr, wr_base and rd_ptr are each ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1). The RAM address is the low ADDR_W bits.
- WrReady = (FreeWords ≠ 0) && (desc_count < MAX_PKTS).
- Accepted write (WrEn && WrReady): mem[wr_ptr] ← WrData, wr_ptr+1, cur_len+1.
- Rejected write (WrEn && !WrReady): the word is dropped, Overflow pulses, and the err flag is set for the current packet.
- Commit, evaluated on the post-write cur_len:
  - err=1: wr_ptr ← wr_base, Drop pulses.
  - cur_len=0: no action.
  - Otherwise: cur_len is pushed to the descriptor FIFO and wr_base ← new wr_ptr.
  - In every case cur_len and err are cleared.
- WrAbort: wr_ptr ← wr_base, cur_len ← 0, err ← 0. Abort takes priority over WrEn and WrCommit in the same cycle; both are ignored.
- Maximum packet length is DEPTH words. Free space counts uncommitted words, so one packet may fill the whole buffer.
- Read side states:
  - IDLE: RdEn is ignored while PktAvail=0. When RdEn && PktAvail, rd_remain ← PktLen−1, one word is read, and the state moves to BURST. If PktLen=1, RdLast is flagged, the head descriptor is popped and the state stays IDLE.
  - BURST: each RdEn reads one word and decrements rd_remain. When rd_remain=0 on an accepted read, that word is flagged last, the head descriptor is popped and the state returns to IDLE.
  - RdEn may stay high across packet boundaries. The next packet starts on the cycle after the pop if PktAvail is still 1.
- Words are freed as they are read (rd_ptr+1 per accepted read).
- Simultaneous descriptor push and pop leaves desc_count unchanged.
- Reset, including mid-packet or mid-read: all pointers, counters, err and the state return to initial values. Any partial or pending packets are lost.

## Timing

- Reset values: WrReady=1, FreeWords=2^ADDR_W, Overflow=0, Drop=0, PktAvail=0, PktLen=0, RdData=0, RdValid=0, RdLast=0.
- Read latency: RdValid, RdData and RdLast appear 1 cycle after the accepted RdEn.
- Commit to PktAvail: 1 cycle. PktAvail and PktLen are registered from the descriptor FIFO.
- Pop to PktAvail/PktLen update: 1 cycle after the last-word RdEn.
- FreeWords and WrReady are registered and reflect a write or read from the previous cycle. A write in the cycle WrReady=1 is always accepted.
- Overflow and Drop are single-cycle pulses, registered.
- Throughput: 1 word/cycle in each direction concurrently.

## Test plan

- After reset, write 5 words 0x11..0x15 with WrCommit on the 5th -> PktAvail=1 and PktLen=5 one cycle later. Hold RdEn for 5 cycles -> RdData 0x11..0x15 at latency 1, RdLast on 0x15, then PktAvail=0.
- Write 3 words, then WrAbort; write 2 words 0xA0,0xA1 and commit -> only a 2-word packet appears; FreeWords=1022 before the read.
- ADDR_W=4: write 17 words, then commit -> Overflow pulses on the 17th word, Drop pulses on the commit, PktAvail stays 0, FreeWords=16.
- Commit MAX_PKTS=4 one-word packets -> WrReady=0 with FreeWords=1020. Reading one packet -> WrReady=1 two cycles after that RdEn.
- Commit packets of lengths 1 and 3, then hold RdEn continuously -> RdLast on the 1st and 4th valid words, with no word lost or duplicated.
- Assert Reset in the middle of a packet read -> all outputs return to their reset values immediately, and a subsequent 1-word packet reads back correctly.

Source files
------------

// File: rtl/packet_buffer_fifo_if.sv
// -----------------------------------------------------------------------------
// packet_buffer_fifo_if
// Handshake bundle between the packet assembler (master) and the packet
// buffer FIFO (slave), including the read side that feeds the transmit framer.
//
// Write side : WrEn, WrData, WrCommit, WrAbort          (master -> slave)
//              WrReady, FreeWords, Overflow, Drop      (slave -> master)
// Read side  : RdEn                                    (master -> slave)
//              PktAvail, PktLen, RdData, RdValid, RdLast (slave -> master)
// -----------------------------------------------------------------------------
interface packet_buffer_fifo_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 11
);
  logic              WrEn;
  logic [DATA_W-1:0] WrData;
  logic              WrCommit;
  logic              WrAbort;
  logic              WrReady;
  logic [LEN_W-1:0]  FreeWords;
  logic              Overflow;
  logic              Drop;
  logic              PktAvail;
  logic [LEN_W-1:0]  PktLen;
  logic              RdEn;
  logic [DATA_W-1:0] RdData;
  logic              RdValid;
  logic              RdLast;

  modport master (
    output WrEn, WrData, WrCommit, WrAbort, RdEn,
    input  WrReady, FreeWords, Overflow, Drop, PktAvail, PktLen, RdData, RdValid, RdLast
  );

  modport slave (
    input  WrEn, WrData, WrCommit, WrAbort, RdEn,
    output WrReady, FreeWords, Overflow, Drop, PktAvail, PktLen, RdData, RdValid, RdLast
  );
endinterface

// File: rtl/packet_buffer_fifo.sv
// -----------------------------------------------------------------------------
// packet_buffer_fifo
// Single-clock packet FIFO. Words of a packet are streamed in and then the
// packet is committed (made visible to the reader with its length) or aborted
// (storage reclaimed). Packets that overflowed are dropped at commit time.
//
// Ports:
//   Clock - rising-edge clock
//   Reset - asynchronous, active-high reset of all pointers, counters, state
//   bus   - packet_buffer_fifo_if.slave (write handshake, status, read side)
// -----------------------------------------------------------------------------
module packet_buffer_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int MAX_PKTS = 4,
  parameter int LEN_W    = ADDR_W + 1
) (
  input logic                Clock,
  input logic                Reset,
  packet_buffer_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;
  localparam int DI_W  = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;
  localparam int DC_W  = DI_W + 1;

  typedef enum logic {IDLE, BURST} rdState_t;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [LEN_W-1:0]  descMem [1 << DI_W];

  logic [PTR_W-1:0] wrPtr, wrBase, rdPtr;
  logic [LEN_W-1:0] curLen, rdRemain;
  logic             err;
  logic [DI_W-1:0]  descWr, descRd;
  logic [DC_W-1:0]  descCount;
  rdState_t         rdState;

  logic             wrAccept, wrReject, errPost, push, dropNext, errNext;
  logic             rdAccept, rdLastWord, pop;
  logic [LEN_W-1:0] lenPost, curLenNext, freeNext;
  logic [PTR_W-1:0] wrPtrNext, wrBaseNext, rdPtrNext;
  logic [DI_W-1:0]  descRdNext;
  logic [DC_W-1:0]  descCountNext;

  // Write-side next state: abort wins over write and commit; commit looks at
  // the packet length and error flag including this cycle's write.
  always_comb begin
    wrAccept   = bus.WrEn && bus.WrReady && !bus.WrAbort;
    wrReject   = bus.WrEn && !bus.WrReady && !bus.WrAbort;
    errPost    = err || wrReject;
    lenPost    = curLen + LEN_W'(wrAccept);
    wrPtrNext  = wrPtr + PTR_W'(wrAccept);
    wrBaseNext = wrBase;
    curLenNext = lenPost;
    errNext    = errPost;
    push       = 1'b0;
    dropNext   = 1'b0;
    if (bus.WrAbort) begin
      wrPtrNext  = wrBase;
      curLenNext = '0;
      errNext    = 1'b0;
    end else if (bus.WrCommit) begin
      curLenNext = '0;
      errNext    = 1'b0;
      if (errPost) begin
        wrPtrNext = wrBase;
        dropNext  = 1'b1;
      end else if (lenPost != '0) begin
        push       = 1'b1;
        wrBaseNext = wrPtrNext;
      end
    end
  end

  // Read-side next state: in IDLE the head descriptor length decides whether
  // the first word is also the last; in BURST the remaining count does.
  always_comb begin
    rdAccept      = bus.RdEn && ((rdState == BURST) || bus.PktAvail);
    rdLastWord    = (rdState == IDLE) ? (bus.PktLen == LEN_W'(1)) : (rdRemain == LEN_W'(1));
    pop           = rdAccept && rdLastWord;
    rdPtrNext     = rdPtr + PTR_W'(rdAccept);
    descRdNext    = descRd + DI_W'(pop);
    descCountNext = descCount + DC_W'(push) - DC_W'(pop);
    freeNext      = LEN_W'(DEPTH) - LEN_W'(wrPtrNext - rdPtrNext);
  end

  always_ff @(posedge Clock) begin
    if (wrAccept) mem[wrPtr[ADDR_W-1:0]] <= bus.WrData;
  end

  always_ff @(posedge Clock) begin
    if (push) descMem[descWr] <= lenPost;
  end

  // Write control and status registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wrPtr         <= '0;
      wrBase        <= '0;
      curLen        <= '0;
      err           <= 1'b0;
      descWr        <= '0;
      descRd        <= '0;
      descCount     <= '0;
      bus.WrReady   <= 1'b1;
      bus.FreeWords <= LEN_W'(DEPTH);
      bus.Overflow  <= 1'b0;
      bus.Drop      <= 1'b0;
      bus.PktAvail  <= 1'b0;
      bus.PktLen    <= '0;
    end else begin
      wrPtr         <= wrPtrNext;
      wrBase        <= wrBaseNext;
      curLen        <= curLenNext;
      err           <= errNext;
      descWr        <= descWr + DI_W'(push);
      descRd        <= descRdNext;
      descCount     <= descCountNext;
      bus.FreeWords <= freeNext;
      // A descriptor slot freed by a pop only becomes usable a cycle later,
      // while a push is accounted for at once so WrReady is never optimistic.
      bus.WrReady   <= (freeNext != '0) && ((descCount + DC_W'(push)) < DC_W'(MAX_PKTS));
      bus.Overflow  <= wrReject;
      bus.Drop      <= dropNext;
      bus.PktAvail  <= (descCountNext != '0);
      if (descCountNext == '0)
        bus.PktLen <= '0;
      else if (push && (descRdNext == descWr))
        bus.PktLen <= lenPost;  // head slot is being written this cycle
      else
        bus.PktLen <= descMem[descRdNext];
    end
  end

  // Read FSM and registered read port (one cycle latency)
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rdState     <= IDLE;
      rdPtr       <= '0;
      rdRemain    <= '0;
      bus.RdData  <= '0;
      bus.RdValid <= 1'b0;
      bus.RdLast  <= 1'b0;
    end else begin
      rdPtr       <= rdPtrNext;
      bus.RdValid <= rdAccept;
      bus.RdLast  <= pop;
      if (rdAccept) begin
        bus.RdData <= mem[rdPtr[ADDR_W-1:0]];
        if (pop) begin
          rdState  <= IDLE;
          rdRemain <= '0;
        end else if (rdState == IDLE) begin
          rdState  <= BURST;
          rdRemain <= bus.PktLen - LEN_W'(1);
        end else begin
          rdRemain <= rdRemain - LEN_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_packet_buffer_fifo.sv
// -----------------------------------------------------------------------------
// tb_packet_buffer_fifo
// Directed bench for packet_buffer_fifo. dutA (1024 words, 4 packets) is
// tracked every cycle against a queue-based packet model; dutB (16 words)
// covers the overflow/drop path with literal expectations.
// -----------------------------------------------------------------------------
module tb_packet_buffer_fifo;
  localparam int DEPTH = 1024;
  localparam int MAXP  = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  packet_buffer_fifo_if #(.DATA_W(8), .LEN_W(11)) busA ();
  packet_buffer_fifo_if #(.DATA_W(8), .LEN_W(5))  busB ();

  packet_buffer_fifo #(.DATA_W(8), .ADDR_W(10), .MAX_PKTS(4), .LEN_W(11)) dutA (
    .Clock(Clock), .Reset(Reset), .bus(busA));
  packet_buffer_fifo #(.DATA_W(8), .ADDR_W(4), .MAX_PKTS(4), .LEN_W(5)) dutB (
    .Clock(Clock), .Reset(Reset), .bus(busB));

  int nTests = 0;
  int nFail  = 0;

  // Packet model: committed words, pending packet lengths, open packet.
  logic [7:0] mCq[$];
  int         mPq[$];
  logic [7:0] mCur[$];
  bit         mErr;
  int         mRemain, mFree, mLen;
  bit         mReady, mAvail, mOvf, mDrop, mValid, mLast;
  logic [7:0] mData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mCq.delete(); mPq.delete(); mCur.delete();
    mErr = 0; mRemain = 0; mFree = DEPTH; mLen = 0;
    mReady = 1; mAvail = 0; mOvf = 0; mDrop = 0; mValid = 0; mLast = 0;
    mData = 8'h00;
  endtask

  // Advances the model over one rising edge using the inputs now on busA.
  task automatic modelStep();
    bit rdAcc, popped, errp;
    if (Reset) begin
      modelReset();
      return;
    end
    popped = 0;
    mDrop  = 0;
    rdAcc  = busA.RdEn && (mRemain > 0 || mAvail);
    mValid = rdAcc;
    mLast  = 0;
    if (rdAcc) begin
      if (mRemain == 0) mRemain = mPq[0];
      mData = mCq.pop_front();
      mRemain--;
      if (mRemain == 0) begin
        mLast = 1;
        void'(mPq.pop_front());
        popped = 1;
      end
    end
    mOvf = 0;
    if (busA.WrAbort) begin
      mCur.delete();
      mErr = 0;
    end else begin
      if (busA.WrEn && mReady) mCur.push_back(busA.WrData);
      mOvf = busA.WrEn && !mReady;
      errp = mErr || mOvf;
      if (busA.WrCommit) begin
        if (errp) mDrop = 1;
        else if (mCur.size() > 0) begin
          mPq.push_back(mCur.size());
          foreach (mCur[i]) mCq.push_back(mCur[i]);
        end
        mCur.delete();
        mErr = 0;
      end else begin
        mErr = errp;
      end
    end
    mAvail = (mPq.size() != 0);
    mLen   = mAvail ? mPq[0] : 0;
    mFree  = DEPTH - mCq.size() - mCur.size();
    mReady = (mFree != 0) && ((mPq.size() + int'(popped)) < MAXP);
  endtask

  // Per-cycle comparison of dutA against the model.
  initial forever begin
    @(negedge Clock);
    chk("WrReady",   busA.WrReady,   32'(mReady));
    chk("FreeWords", busA.FreeWords, mFree);
    chk("Overflow",  busA.Overflow,  32'(mOvf));
    chk("Drop",      busA.Drop,      32'(mDrop));
    chk("PktAvail",  busA.PktAvail,  32'(mAvail));
    chk("PktLen",    busA.PktLen,    mLen);
    chk("RdValid",   busA.RdValid,   32'(mValid));
    chk("RdLast",    busA.RdLast,    32'(mLast));
    chk("RdData",    busA.RdData,    32'(mData));
  end

  task automatic step();
    modelStep();
    @(posedge Clock);
    @(negedge Clock);
    #1;
  endtask

  task automatic idleA();
    busA.WrEn = 0; busA.WrData = 8'h00; busA.WrCommit = 0; busA.WrAbort = 0; busA.RdEn = 0;
  endtask

  task automatic wr(input logic [7:0] d, input logic commit);
    busA.WrEn = 1; busA.WrData = d; busA.WrCommit = commit;
    step();
    busA.WrEn = 0; busA.WrCommit = 0;
  endtask

  task automatic rd(input logic [7:0] d, input logic last);
    busA.RdEn = 1;
    step();
    chk("rd valid", busA.RdValid, 1);
    chk("rd data",  busA.RdData,  32'(d));
    chk("rd last",  busA.RdLast,  32'(last));
  endtask

  task automatic chkResetA(input string tag);
    chk({tag, " WrReady"},   busA.WrReady,   1);
    chk({tag, " FreeWords"}, busA.FreeWords, 1024);
    chk({tag, " Overflow"},  busA.Overflow,  0);
    chk({tag, " Drop"},      busA.Drop,      0);
    chk({tag, " PktAvail"},  busA.PktAvail,  0);
    chk({tag, " PktLen"},    busA.PktLen,    0);
    chk({tag, " RdData"},    busA.RdData,    0);
    chk({tag, " RdValid"},   busA.RdValid,   0);
    chk({tag, " RdLast"},    busA.RdLast,    0);
  endtask

  initial begin
    idleA();
    busB.WrEn = 0; busB.WrData = 8'h00; busB.WrCommit = 0; busB.WrAbort = 0; busB.RdEn = 0;
    modelReset();
    repeat (2) @(negedge Clock);
    #1;
    chkResetA("reset");
    chk("B reset FreeWords", busB.FreeWords, 16);
    chk("B reset WrReady",   busB.WrReady,   1);
    Reset = 0;

    // 16-word buffer: 17 writes then commit -> overflow, drop, space returned
    for (int i = 0; i < 17; i++) begin
      busB.WrEn = 1; busB.WrData = 8'(i);
      step();
      if (i == 15) begin
        chk("B full WrReady",   busB.WrReady,   0);
        chk("B full FreeWords", busB.FreeWords, 0);
        chk("B no Overflow",    busB.Overflow,  0);
      end
    end
    chk("B Overflow", busB.Overflow, 1);
    busB.WrEn = 0; busB.WrCommit = 1;
    step();
    busB.WrCommit = 0;
    chk("B Drop",        busB.Drop,      1);
    chk("B PktAvail",    busB.PktAvail,  0);
    chk("B FreeWords",   busB.FreeWords, 16);
    chk("B Overflow end", busB.Overflow, 0);
    step();
    chk("B Drop pulse", busB.Drop,     0);
    chk("B WrReady",    busB.WrReady,  1);
    chk("B PktAvail 2", busB.PktAvail, 0);

    // 5-word packet, read back with RdEn held
    for (int i = 0; i < 5; i++) wr(8'(8'h11 + i), (i == 4));
    chk("p5 PktAvail",  busA.PktAvail,  1);
    chk("p5 PktLen",    busA.PktLen,    5);
    chk("p5 FreeWords", busA.FreeWords, 1019);
    for (int i = 0; i < 5; i++) rd(8'(8'h11 + i), (i == 4));
    chk("p5 drained", busA.PktAvail, 0);
    busA.RdEn = 0;
    step();
    chk("p5 idle RdValid", busA.RdValid, 0);

    // Abort then a 2-word packet
    wr(8'h01, 0); wr(8'h02, 0); wr(8'h03, 0);
    chk("abort pre FreeWords", busA.FreeWords, 1021);
    busA.WrAbort = 1;
    step();
    busA.WrAbort = 0;
    chk("abort FreeWords", busA.FreeWords, 1024);
    chk("abort PktAvail",  busA.PktAvail,  0);
    wr(8'hA0, 0); wr(8'hA1, 1);
    chk("p2 PktLen",    busA.PktLen,    2);
    chk("p2 FreeWords", busA.FreeWords, 1022);
    rd(8'hA0, 0); rd(8'hA1, 1);
    busA.RdEn = 0;
    step();

    // Descriptor FIFO full
    for (int i = 0; i < 4; i++) begin
      wr(8'(8'h30 + i), 1);
      if (i == 2) chk("desc3 WrReady", busA.WrReady, 1);
    end
    chk("desc full WrReady",   busA.WrReady,   0);
    chk("desc full FreeWords", busA.FreeWords, 1020);
    busA.WrEn = 1; busA.WrData = 8'hEE; busA.WrCommit = 1;
    step();
    busA.WrEn = 0; busA.WrCommit = 0;
    chk("rejected Overflow", busA.Overflow, 1);
    chk("rejected Drop",     busA.Drop,     1);
    busA.RdEn = 1;
    step();
    busA.RdEn = 0;
    chk("pop RdData",    busA.RdData,  8'h30);
    chk("pop RdLast",    busA.RdLast,  1);
    chk("pop +1 WrReady", busA.WrReady, 0);
    step();
    chk("pop +2 WrReady",  busA.WrReady,   1);
    chk("pop +2 FreeWords", busA.FreeWords, 1021);
    for (int i = 1; i < 4; i++) rd(8'(8'h30 + i), 1);
    busA.RdEn = 0;
    step();
    chk("desc drained", busA.PktAvail, 0);

    // Lengths 1 and 3 with RdEn held; a 2-word packet written during the read
    wr(8'h41, 1); wr(8'h51, 0); wr(8'h52, 0); wr(8'h53, 1);
    chk("1+3 PktLen", busA.PktLen, 1);
    rd(8'h41, 1);
    busA.WrEn = 1; busA.WrData = 8'h61;
    rd(8'h51, 0);
    busA.WrData = 8'h62; busA.WrCommit = 1;
    rd(8'h52, 0);
    busA.WrEn = 0; busA.WrCommit = 0;
    rd(8'h53, 1);
    chk("next PktLen", busA.PktLen, 2);
    rd(8'h61, 0); rd(8'h62, 1);
    step();
    chk("empty RdEn ignored", busA.RdValid, 0);
    busA.RdEn = 0;

    // Reset in the middle of a packet read
    wr(8'h71, 0); wr(8'h72, 0); wr(8'h73, 1);
    rd(8'h71, 0);
    #2;
    Reset = 1;
    idleA();
    modelReset();
    #1;
    chkResetA("mid reset");
    step();
    step();
    Reset = 0;
    wr(8'h99, 1);
    chk("post reset PktLen",    busA.PktLen,    1);
    chk("post reset FreeWords", busA.FreeWords, 1023);
    rd(8'h99, 1);
    busA.RdEn = 0;
    step();
    chk("post reset PktAvail", busA.PktAvail, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
